mpram_wr_sched: RTL and testbench

Write-side scheduler that sits directly upstream of the N-read/N-write multiport RAM and drives its `wa`/`we`/`din` ports. Each write port has an independent valid/ready request channel backed by a small FIFO. The block issues at most one write per port per cycle. When two port heads target the same address in the same cycle, it serialises them, because the RAM's same-cycle same-address writes are undefined. RAM-facing outputs are registered and match the RAM port shapes exactly.

---
 rtl/mpram_wr_sched.sv | 142 ++++++++++++++
 tb/tb_mpram_wr_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mpram_wr_sched.sv
// Write scheduler in front of the multiport RAM: one FIFO per write port, at most one
// write per port per cycle, same-address heads serialised so the RAM never sees a same-cycle clash.
module mpram_wr_sched #(
    parameter int Width     = 8,
    parameter int Depth     = 32,
    parameter int WrNum     = 2,
    parameter int FifoDepth = 2,
    localparam int AW       = $clog2(Depth)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WrNum-1:0]             req_valid,
    output logic [WrNum-1:0]             req_ready,
    input  logic [WrNum-1:0][AW-1:0]     req_addr,
    input  logic [WrNum-1:0][Width-1:0]  req_data,
    output logic [WrNum-1:0][AW-1:0]     wa,
    output logic [WrNum-1:0]             we,
    output logic [WrNum-1:0][Width-1:0]  din,
    output logic [WrNum-1:0]             collide,
    output logic                         idle
);

    localparam int CW = $clog2(FifoDepth + 1);
    localparam int PW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

    logic [AW-1:0]    mem_addr_q [WrNum][FifoDepth];
    logic [Width-1:0] mem_data_q [WrNum][FifoDepth];

    logic [PW-1:0] rd_ptr_q [WrNum];
    logic [PW-1:0] rd_ptr_d [WrNum];
    logic [PW-1:0] wr_ptr_q [WrNum];
    logic [PW-1:0] wr_ptr_d [WrNum];
    logic [CW-1:0] count_q  [WrNum];
    logic [CW-1:0] count_d  [WrNum];

    logic [WrNum-1:0] blocked_q, blocked_d;
    logic [WrNum-1:0] cand, gnt, push;
    logic [AW-1:0]    head_addr [WrNum];
    logic [Width-1:0] head_data [WrNum];

    logic [WrNum-1:0]            we_q, collide_q;
    logic [WrNum-1:0][AW-1:0]    wa_q;
    logic [WrNum-1:0][Width-1:0] din_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        idle = ~|we_q;
        for (int i = 0; i < WrNum; i++) begin
            head_addr[i] = mem_addr_q[i][rd_ptr_q[i]];
            head_data[i] = mem_data_q[i][rd_ptr_q[i]];
            cand[i]      = (count_q[i] != '0);
            req_ready[i] = (count_q[i] != CW'(FifoDepth));
            push[i]      = req_valid[i] & req_ready[i];
            if (count_q[i] != '0) idle = 1'b0;
        end
    end

    // Within a same-address group, a previously held port outranks everyone else.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < WrNum; i++) begin
            logic conflict, any_blk, lower, lower_blk;
            conflict  = 1'b0;
            any_blk   = 1'b0;
            lower     = 1'b0;
            lower_blk = 1'b0;
            for (int j = 0; j < WrNum; j++) begin
                if (j != i && cand[j] && head_addr[j] == head_addr[i]) begin
                    conflict = 1'b1;
                    if (blocked_q[j]) any_blk = 1'b1;
                    if (j < i) begin
                        lower = 1'b1;
                        if (blocked_q[j]) lower_blk = 1'b1;
                    end
                end
            end
            if (cand[i]) begin
                if (!conflict)                    gnt[i] = 1'b1;
                else if (blocked_q[i] || any_blk) gnt[i] = blocked_q[i] & ~lower_blk;
                else                              gnt[i] = ~lower;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WrNum; i++) begin
            rd_ptr_d[i] = gnt[i]  ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
            wr_ptr_d[i] = push[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
            count_d[i]  = count_q[i];
            if (push[i] && !gnt[i])      count_d[i] = count_q[i] + CW'(1);
            else if (!push[i] && gnt[i]) count_d[i] = count_q[i] - CW'(1);
            blocked_d[i] = cand[i] & ~gnt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WrNum; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            blocked_q <= '0;
            we_q      <= '0;
            collide_q <= '0;
            wa_q      <= '0;
            din_q     <= '0;
        end else begin
            for (int i = 0; i < WrNum; i++) begin
                rd_ptr_q[i] <= rd_ptr_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                count_q[i]  <= count_d[i];
                if (gnt[i]) begin
                    wa_q[i]  <= head_addr[i];
                    din_q[i] <= head_data[i];
                end
            end
            blocked_q <= blocked_d;
            we_q      <= gnt;
            collide_q <= cand & ~gnt;
        end
    end

    // Storage needs no reset: an entry is only read once the count covers it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WrNum; i++) begin
            if (push[i]) begin
                mem_addr_q[i][wr_ptr_q[i]] <= req_addr[i];
                mem_data_q[i][wr_ptr_q[i]] <= req_data[i];
            end
        end
    end

    assign wa      = wa_q;
    assign we      = we_q;
    assign din     = din_q;
    assign collide = collide_q;

endmodule

// File: tb/tb_mpram_wr_sched.sv
// Randomised bench for mpram_wr_sched: queue-based model of the grant rules checked every
// cycle, plus directed scenarios with literal expectations and a shadow of the downstream RAM.
module tb_mpram_wr_sched;

    localparam int Width = 8;
    localparam int Depth = 32;
    localparam int WrNum = 2;
    localparam int FD    = 2;
    localparam int AW    = $clog2(Depth);

    typedef struct {
        logic [AW-1:0]    a;
        logic [Width-1:0] d;
    } ent_t;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [WrNum-1:0]            req_valid = '0;
    logic [WrNum-1:0]            req_ready;
    logic [WrNum-1:0][AW-1:0]    req_addr = '0;
    logic [WrNum-1:0][Width-1:0] req_data = '0;
    logic [WrNum-1:0][AW-1:0]    wa;
    logic [WrNum-1:0]            we;
    logic [WrNum-1:0][Width-1:0] din;
    logic [WrNum-1:0]            collide;
    logic                        idle;

    mpram_wr_sched #(.Width(Width), .Depth(Depth), .WrNum(WrNum), .FifoDepth(FD)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .wa(wa), .we(we), .din(din),
        .collide(collide), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    ent_t                        mq [WrNum][$];
    logic [WrNum-1:0]            m_blk = '0;
    logic [WrNum-1:0]            m_we = '0;
    logic [WrNum-1:0]            m_col = '0;
    logic [WrNum-1:0][AW-1:0]    m_wa = '0;
    logic [WrNum-1:0][Width-1:0] m_din = '0;
    logic [Width-1:0]            ram [Depth];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WrNum-1:0] m_ready();
        logic [WrNum-1:0] r;
        for (int i = 0; i < WrNum; i++) r[i] = (mq[i].size() != FD);
        return r;
    endfunction

    // One clock edge of the scheduler, expressed directly from the grant rules.
    task automatic model_step();
        logic [WrNum-1:0] cand, gnt, rdy;
        if (rst) begin
            for (int i = 0; i < WrNum; i++) mq[i].delete();
            m_blk = '0; m_we = '0; m_col = '0; m_wa = '0; m_din = '0;
            return;
        end
        rdy  = m_ready();
        cand = '0;
        gnt  = '0;
        for (int i = 0; i < WrNum; i++) cand[i] = (mq[i].size() > 0);
        for (int i = 0; i < WrNum; i++) begin
            int members[$];
            int winner;
            if (!cand[i]) continue;
            for (int j = 0; j < WrNum; j++)
                if (cand[j] && mq[j][0].a == mq[i][0].a) members.push_back(j);
            winner = -1;
            foreach (members[k]) if (winner < 0 && m_blk[members[k]]) winner = members[k];
            if (winner < 0) winner = members[0];
            gnt[i] = (winner == i);
        end
        for (int i = 0; i < WrNum; i++) begin
            m_we[i]  = gnt[i];
            m_col[i] = cand[i] & ~gnt[i];
            m_blk[i] = cand[i] & ~gnt[i];
            if (gnt[i]) begin
                m_wa[i]  = mq[i][0].a;
                m_din[i] = mq[i][0].d;
                void'(mq[i].pop_front());
            end
            if (req_valid[i] && rdy[i]) mq[i].push_back('{a: req_addr[i], d: req_data[i]});
        end
    endtask

    task automatic compare_all();
        logic empty;
        empty = 1'b1;
        for (int i = 0; i < WrNum; i++) if (mq[i].size() != 0) empty = 1'b0;
        check("req_ready", 64'(req_ready), 64'(m_ready()));
        check("we", 64'(we), 64'(m_we));
        check("collide", 64'(collide), 64'(m_col));
        check("idle", 64'(idle), 64'(empty & ~|m_we));
        for (int i = 0; i < WrNum; i++) begin
            check($sformatf("wa[%0d]", i), 64'(wa[i]), 64'(m_wa[i]));
            check($sformatf("din[%0d]", i), 64'(din[i]), 64'(m_din[i]));
            if (we[i]) ram[wa[i]] = din[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        for (int a = 0; a < Depth; a++) ram[a] = '0;

        // Reset held two cycles with valid asserted: nothing may be queued.
        req_valid = '1;
        step();
        step();
        check("rst_we", 64'(we), 64'h0);
        check("rst_ready", 64'(req_ready), 64'h3);
        check("rst_idle", 64'(idle), 64'h1);
        rst = 1'b0;
        req_valid = '0;
        step();
        check("rst_no_push_idle", 64'(idle), 64'h1);

        // Independent addresses go straight through.
        req_valid = 2'b11;
        req_addr[0] = 5'd3; req_data[0] = 8'h0C;
        req_addr[1] = 5'd4; req_data[1] = 8'hEF;
        step();
        req_valid = '0;
        step();
        check("indep_we", 64'(we), 64'h3);
        check("indep_wa0", 64'(wa[0]), 64'd3);
        check("indep_wa1", 64'(wa[1]), 64'd4);
        check("indep_col", 64'(collide), 64'h0);
        step();
        check("indep_ram3", 64'(ram[3]), 64'h0C);
        check("indep_ram4", 64'(ram[4]), 64'hEF);

        // Same-address pair: port0 first, port1 one cycle later, port1 data survives.
        req_valid = 2'b11;
        req_addr[0] = 5'd5; req_data[0] = 8'h11;
        req_addr[1] = 5'd5; req_data[1] = 8'h22;
        step();
        req_valid = '0;
        step();
        check("conf_we1", 64'(we), 64'h1);
        check("conf_col1", 64'(collide), 64'h2);
        step();
        check("conf_we2", 64'(we), 64'h2);
        check("conf_col2", 64'(collide), 64'h0);
        step();
        check("conf_ram5", 64'(ram[5]), 64'h22);

        // Port0 streams to addr 7 while port1 waits on the same address.
        req_valid = 2'b11;
        req_addr[0] = 5'd7; req_data[0] = 8'h31;
        req_addr[1] = 5'd7; req_data[1] = 8'h32;
        step();
        req_valid = 2'b01; req_data[0] = 8'h40;
        step();
        check("starve_we1", 64'(we), 64'h1);
        check("starve_col1", 64'(collide), 64'h2);
        req_data[0] = 8'h41;
        step();
        check("starve_we2", 64'(we), 64'h2);
        check("starve_col2", 64'(collide), 64'h1);
        check("bp_ready", 64'(req_ready), 64'h2);
        req_data[0] = 8'h42;
        step();
        check("starve_we3", 64'(we), 64'h1);
        check("starve_col3", 64'(collide), 64'h0);
        req_valid = '0;
        for (int n = 0; n < 4; n++) step();
        check("drain_idle", 64'(idle), 64'h1);

        // Reset in the middle of queued conflicting traffic.
        req_valid = 2'b11;
        req_addr[0] = 5'd9; req_addr[1] = 5'd9;
        for (int n = 0; n < 3; n++) begin
            req_data[0] = 8'(8'h50 + n);
            req_data[1] = 8'(8'h60 + n);
            step();
        end
        #2 rst = 1'b1;
        #1;
        check("mid_rst_we", 64'(we), 64'h0);
        check("mid_rst_idle", 64'(idle), 64'h1);
        check("mid_rst_ready", 64'(req_ready), 64'h3);
        req_valid = '0;
        step();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            check("post_rst_we", 64'(we), 64'h0);
        end

        // Random traffic over a narrow address range to force frequent conflicts.
        for (int n = 0; n < 2500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < WrNum; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                req_addr[i]  = AW'($urandom_range(0, 3));
                req_data[i]  = Width'($urandom);
            end
            step();
        end
        rst = 1'b0;
        req_valid = '0;
        for (int n = 0; n < 6; n++) step();
        check("final_idle", 64'(idle), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
